data_port_lsu: RTL and testbench

Load/store unit that sits between the CPU data-access stage and data port B of the 1 KB dual-byte-lane block RAM. It accepts byte and word loads and stores at any byte address. It splits misaligned word accesses into two RAM cycles, steers bytes onto the high/low lanes, and sign- or zero-extends byte loads. It returns one registered response per request.

---
 rtl/data_port_lsu_pkg.sv | 17 +
 rtl/data_port_lsu_lane_align.sv | 38 +++
 rtl/data_port_lsu.sv | 178 +++++++++++++++++
 tb/tb_data_port_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_port_lsu_pkg.sv
// Shared definitions for the data-port load/store unit: address widths,
// lane-select encoding and FSM state encoding.
package data_port_lsu_pkg;
    localparam int ADDR_W  = 10;
    localparam int WADDR_W = 9;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DATA,
        S_RD_LO,
        S_RD_HI,
        S_WR_HI
    } lsu_state_e;
endpackage

// File: rtl/data_port_lsu_lane_align.sv
// Combinational lane swizzle: store write-enable/data steering for the first
// RAM cycle of a store, and lane selection plus extension for single-cycle loads.
module lsu_lane_align
    import data_port_lsu_pkg::*;
(
    input  logic        st_lane,
    input  logic        st_byte,
    input  logic [15:0] st_wdata,
    output logic        st_we_h,
    output logic        st_we_l,
    output logic [7:0]  st_din_h,
    output logic [7:0]  st_din_l,
    input  logic        ld_lane,
    input  logic        ld_byte,
    input  logic        ld_sext,
    input  logic [7:0]  dout_h,
    input  logic [7:0]  dout_l,
    output logic [15:0] ld_data
);
    function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sext);
        logic signed [7:0] b_s;
        b_s = b;
        return sext ? 16'(b_s) : {8'h00, b};
    endfunction

    logic st_single;
    logic [7:0] ld_sel;

    // A misaligned word store starts exactly like a byte store to the high lane.
    assign st_single = st_byte | (st_lane == LANE_HI);
    assign st_we_h   = ~st_single | (st_lane == LANE_HI);
    assign st_we_l   = ~st_single | (st_lane == LANE_LO);
    assign st_din_h  = st_single ? st_wdata[7:0] : st_wdata[15:8];
    assign st_din_l  = st_wdata[7:0];

    assign ld_sel  = (ld_lane == LANE_HI) ? dout_h : dout_l;
    assign ld_data = ld_byte ? extend_byte(ld_sel, ld_sext) : {dout_h, dout_l};
endmodule

// File: rtl/data_port_lsu.sv
// Load/store unit between the CPU data stage and RAM port B: splits misaligned
// word accesses into two RAM cycles and returns one registered response per request.
module data_port_lsu
    import data_port_lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_byte,
    input  logic        i_req_sext,
    input  logic [9:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_b_en,
    output logic        o_b_we_h,
    output logic        o_b_we_l,
    output logic [8:0]  o_b_addr,
    output logic [7:0]  o_b_din_h,
    output logic [7:0]  o_b_din_l,
    input  logic [7:0]  i_b_dout_h,
    input  logic [7:0]  i_b_dout_l
);
    lsu_state_e state, state_nxt;

    logic               accept;
    logic               req_mis;
    logic [WADDR_W-1:0] req_waddr;

    logic               byte_p1;
    logic               sext_p1;
    logic               lane_p1;
    logic [WADDR_W-1:0] waddr_nxt_p1;
    logic [7:0]         whi_p1;
    logic [7:0]         lo_p2;

    logic               rsp_valid;
    logic [15:0]        rsp_rdata;

    logic               st_we_h, st_we_l;
    logic [7:0]         st_din_h, st_din_l;
    logic [15:0]        ld_data;

    logic               b_en, b_we_h, b_we_l;
    logic [WADDR_W-1:0] b_addr;
    logic [7:0]         b_din_h, b_din_l;

    assign o_req_ready = (state == S_IDLE) & ~i_rst;
    assign accept      = i_req_valid & o_req_ready;
    assign req_waddr   = i_req_addr[ADDR_W-1:1];
    assign req_mis     = ~i_req_byte & i_req_addr[0];

    lsu_lane_align u_lane_align (
        .st_lane  (i_req_addr[0]),
        .st_byte  (i_req_byte),
        .st_wdata (i_req_wdata),
        .st_we_h  (st_we_h),
        .st_we_l  (st_we_l),
        .st_din_h (st_din_h),
        .st_din_l (st_din_l),
        .ld_lane  (lane_p1),
        .ld_byte  (byte_p1),
        .ld_sext  (sext_p1),
        .dout_h   (i_b_dout_h),
        .dout_l   (i_b_dout_l),
        .ld_data  (ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        b_en      = 1'b0;
        b_we_h    = 1'b0;
        b_we_l    = 1'b0;
        b_addr    = '0;
        b_din_h   = '0;
        b_din_l   = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    b_en   = 1'b1;
                    b_addr = req_waddr;
                    if (i_req_we) begin
                        b_we_h    = st_we_h;
                        b_we_l    = st_we_l;
                        b_din_h   = st_din_h;
                        b_din_l   = st_din_l;
                        state_nxt = req_mis ? S_WR_HI : S_IDLE;
                    end else begin
                        state_nxt = req_mis ? S_RD_LO : S_RD_DATA;
                    end
                end
            end
            S_RD_DATA: state_nxt = S_IDLE;
            S_RD_LO: begin
                b_en      = 1'b1;
                b_addr    = waddr_nxt_p1;
                state_nxt = S_RD_HI;
            end
            S_RD_HI: state_nxt = S_IDLE;
            S_WR_HI: begin
                b_en      = 1'b1;
                b_we_l    = 1'b1;
                b_addr    = waddr_nxt_p1;
                b_din_l   = whi_p1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (i_rst) begin
            state_nxt = S_IDLE;
            b_en      = 1'b0;
            b_we_h    = 1'b0;
            b_we_l    = 1'b0;
            b_addr    = '0;
            b_din_h   = '0;
            b_din_l   = '0;
        end
    end

    // Stage p1: request fields captured at accept for the later RAM cycles.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            byte_p1      <= i_req_byte;
            sext_p1      <= i_req_sext;
            lane_p1      <= i_req_addr[0];
            waddr_nxt_p1 <= req_waddr + 9'd1;
            whi_p1       <= i_req_wdata[15:8];
        end
        if (state == S_RD_LO) lo_p2 <= i_b_dout_h;
    end

    // Response register: pulses in the cycle the FSM re-enters IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && i_req_we && !req_mis) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                S_RD_DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                end
                S_RD_HI: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= {i_b_dout_l, lo_p2};
                end
                S_WR_HI: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid;
    assign o_rsp_rdata = rsp_rdata;
    assign o_b_en      = b_en;
    assign o_b_we_h    = b_we_h;
    assign o_b_we_l    = b_we_l;
    assign o_b_addr    = b_addr;
    assign o_b_din_h   = b_din_h;
    assign o_b_din_l   = b_din_l;
endmodule

// File: tb/tb_data_port_lsu.sv
// Bench for data_port_lsu: a behavioural dual-lane RAM on port B, a table of
// requests with expected data/latency/enable counts, and hand-written corner sequences.
module tb_data_port_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_byte, req_sext;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        b_en, b_we_h, b_we_l;
    logic [8:0]  b_addr;
    logic [7:0]  b_din_h, b_din_l, b_dout_h, b_dout_l;

    logic [7:0] mem_h [512];
    logic [7:0] mem_l [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_port_lsu dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_byte  (req_byte),
        .i_req_sext  (req_sext),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_b_en      (b_en),
        .o_b_we_h    (b_we_h),
        .o_b_we_l    (b_we_l),
        .o_b_addr    (b_addr),
        .o_b_din_h   (b_din_h),
        .o_b_din_l   (b_din_l),
        .i_b_dout_h  (b_dout_h),
        .i_b_dout_l  (b_dout_l)
    );

    // Read-first synchronous RAM, data valid the cycle after enable.
    always @(posedge clk) begin
        if (b_en) begin
            if (b_we_h) mem_h[b_addr] <= b_din_h;
            if (b_we_l) mem_l[b_addr] <= b_din_l;
            b_dout_h <= mem_h[b_addr];
            b_dout_l <= mem_l[b_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic byt, input logic sext,
                         input logic [9:0] addr, input logic [15:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byt;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic wait_rsp(output int lat, output logic [15:0] rd, inout int ens);
        lat = 0;
        rd  = 16'h0000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (b_en) ens++;
            if (rsp_valid) begin
                lat = c;
                rd  = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic run_req(input string name, input logic we, input logic byt, input logic sext,
                           input logic [9:0] addr, input logic [15:0] wd,
                           input logic [15:0] exp_rd, input int exp_lat, input int exp_ens);
        int lat;
        int ens;
        logic [15:0] rd;
        @(negedge clk);
        drive(we, byt, sext, addr, wd);
        #1;
        check({name, " ready"}, 32'(req_ready), 32'd1);
        ens = b_en ? 1 : 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat, rd, ens);
        check({name, " rdata"}, 32'(rd), 32'(exp_rd));
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " en_count"}, 32'(ens), 32'(exp_ens));
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic        byt;
        logic        sext;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_ens;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic we, input logic byt, input logic sext,
                       input logic [9:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input int exp_lat, input int exp_ens);
        vecs.push_back('{name, we, byt, sext, addr, wd, exp_rd, exp_lat, exp_ens});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ens;
        logic rsp_seen;
        logic [15:0] rd;

        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 10'h000, 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst en", 32'(b_en), 32'd0);
        check("rst we", 32'({b_we_h, b_we_l}), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", 32'(rsp_rdata), 32'd0);
        check("rst addr_din", 32'({b_addr, b_din_h, b_din_l}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post-rst ready", 32'(req_ready), 32'd1);
        check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);

        //   name          we    byte  sext  addr     wdata     rdata     lat en
        add("pre w0",     1'b1, 1'b0, 1'b0, 10'h000, 16'h1234, 16'h0000, 1, 1);
        add("pre w1",     1'b1, 1'b0, 1'b0, 10'h002, 16'h5678, 16'h0000, 1, 1);
        add("ldw 002",    1'b0, 1'b0, 1'b0, 10'h002, 16'h0000, 16'h5678, 2, 1);
        add("ldw 000",    1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h1234, 2, 1);
        add("ldw 001",    1'b0, 1'b0, 1'b0, 10'h001, 16'h0000, 16'h7812, 3, 2);
        add("ldb 000 s",  1'b0, 1'b1, 1'b1, 10'h000, 16'h0000, 16'h0034, 2, 1);
        add("ldb 003 s",  1'b0, 1'b1, 1'b1, 10'h003, 16'h0000, 16'h0056, 2, 1);
        add("stb 001",    1'b1, 1'b1, 1'b0, 10'h001, 16'h3392, 16'h0000, 1, 1);
        add("ldb 001 s",  1'b0, 1'b1, 1'b1, 10'h001, 16'h0000, 16'hFF92, 2, 1);
        add("ldb 001 z",  1'b0, 1'b1, 1'b0, 10'h001, 16'h0000, 16'h0092, 2, 1);
        add("stw 3FF",    1'b1, 1'b0, 1'b0, 10'h3FF, 16'hBEEF, 16'h0000, 2, 2);
        add("ldw 3FF",    1'b0, 1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hBEEF, 3, 2);
        add("ldw 000 b",  1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h92BE, 2, 1);
        add("stw 004",    1'b1, 1'b0, 1'b0, 10'h004, 16'hCAFE, 16'h0000, 1, 1);
        add("ldb 005 z",  1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 16'h00CA, 2, 1);
        add("ldb 005 s",  1'b0, 1'b1, 1'b1, 10'h005, 16'h0000, 16'hFFCA, 2, 1);
        add("ldb 004 s",  1'b0, 1'b1, 1'b1, 10'h004, 16'h0000, 16'hFFFE, 2, 1);
        add("stw 003",    1'b1, 1'b0, 1'b0, 10'h003, 16'h1122, 16'h0000, 2, 2);
        add("ldw 002 b",  1'b0, 1'b0, 1'b1, 10'h002, 16'h0000, 16'h2278, 2, 1);
        add("ldw 004 b",  1'b0, 1'b0, 1'b0, 10'h004, 16'h0000, 16'hCA11, 2, 1);
        add("stw 006",    1'b1, 1'b0, 1'b0, 10'h006, 16'h5555, 16'h0000, 1, 1);
        add("stb 006",    1'b1, 1'b1, 1'b0, 10'h006, 16'hFF77, 16'h0000, 1, 1);
        add("ldw 006",    1'b0, 1'b0, 1'b0, 10'h006, 16'h0000, 16'h5577, 2, 1);

        foreach (vecs[i])
            run_req(vecs[i].name, vecs[i].we, vecs[i].byt, vecs[i].sext, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_lat, vecs[i].exp_ens);

        // Read-after-write with the load accepted in the store's ack cycle.
        run_req("raw pre w0", 1'b1, 1'b0, 1'b0, 10'h000, 16'h1234, 16'h0000, 1, 1);
        run_req("raw pre w1", 1'b1, 1'b0, 1'b0, 10'h002, 16'h5678, 16'h0000, 1, 1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 10'h001, 16'h00AA);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(negedge clk);
        check("raw store ack", 32'(rsp_valid), 32'd1);
        check("raw ready in ack", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ens = 0;
        wait_rsp(lat, rd, ens);
        check("raw load rdata", 32'(rd), 32'hAA34);
        check("raw load latency", 32'(lat), 32'd2);

        // Misaligned store at the top of memory: port-level view of both cycles.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 10'h3FF, 16'hBEEF);
        #1;
        check("wrap T en/we", 32'({b_en, b_we_h, b_we_l}), 32'b110);
        check("wrap T addr", 32'(b_addr), 32'h1FF);
        check("wrap T din_h", 32'(b_din_h), 32'hEF);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wrap T1 en/we", 32'({b_en, b_we_h, b_we_l}), 32'b101);
        check("wrap T1 addr", 32'(b_addr), 32'h000);
        check("wrap T1 din_l", 32'(b_din_l), 32'hBE);
        check("wrap T1 rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("wrap T2 rsp", 32'({rsp_valid, req_ready}), 32'b11);
        check("wrap T2 rdata", 32'(rsp_rdata), 32'h0000);
        @(negedge clk);
        check("wrap T3 rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset during RD_LO of a misaligned load discards the second access.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 10'h001, 16'h0000);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rdlo rst en", 32'(b_en), 32'd0);
        check("rdlo rst ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rdlo ready after rst", 32'(req_ready), 32'd1);
        ens = 0;
        rsp_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b_en) ens++;
            rsp_seen = rsp_seen | rsp_valid;
        end
        check("rdlo rst no en", 32'(ens), 32'd0);
        check("rdlo rst no rsp", 32'(rsp_seen), 32'd0);

        run_req("after rst ldw 002", 1'b0, 1'b0, 1'b0, 10'h002, 16'h0000, 16'h5678, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
